// File: rtl/region_redraw_engine_if.sv
// Bundle of request, background-ROM, VGA-plot and sprite-handoff signals for region_redraw_engine.
// The engine connects through the slave modport; the controller/ROM/VGA side uses master.
interface region_redraw_engine_if #(
   parameter int X_W     = 9,
   parameter int Y_W     = 8,
   parameter int COLOR_W = 3
);
   logic               start;
   logic               full_screen;
   logic [X_W-1:0]     rect_x0;
   logic [Y_W-1:0]     rect_y0;
   logic [X_W-1:0]     rect_w;
   logic [Y_W-1:0]     rect_h;
   logic [X_W-1:0]     rom_x;
   logic [Y_W-1:0]     rom_y;
   logic [COLOR_W-1:0] rom_color;
   logic [X_W-1:0]     vga_x;
   logic [Y_W-1:0]     vga_y;
   logic [COLOR_W-1:0] vga_color;
   logic               vga_plot;
   logic               sprite_go;
   logic               sprite_done;
   logic               busy;
   logic               done_redraw;

   modport master (
      output start, full_screen, rect_x0, rect_y0, rect_w, rect_h, rom_color, sprite_done,
      input  rom_x, rom_y, vga_x, vga_y, vga_color, vga_plot, sprite_go, busy, done_redraw
   );

   modport slave (
      input  start, full_screen, rect_x0, rect_y0, rect_w, rect_h, rom_color, sprite_done,
      output rom_x, rom_y, vga_x, vga_y, vga_color, vga_plot, sprite_go, busy, done_redraw
   );
endinterface

// File: rtl/region_redraw_engine.sv
// Redraws a clipped rectangle (or the whole screen) from the background ROM at one pixel per
// clock, then hands off to the sprite drawer and pulses completion.
//
// state  | meaning
// IDLE   | waiting for start; latches and clips the region
// SCAN   | issuing one ROM address per cycle, raster order, x fastest
// DRAIN  | waiting ROM_LAT cycles for in-flight pixels to be plotted
// SPRITE | sprite_go high until sprite_done
// DONE   | one-cycle done_redraw pulse
module region_redraw_engine #(
   parameter int SCREEN_W = 320,
   parameter int SCREEN_H = 240,
   parameter int X_W      = 9,
   parameter int Y_W      = 8,
   parameter int COLOR_W  = 3,
   parameter int ROM_LAT  = 1
) (
   input logic                   i_clock,
   input logic                   i_resetn,
   region_redraw_engine_if.slave bus
);
   typedef enum logic [2:0] {S_IDLE, S_SCAN, S_DRAIN, S_SPRITE, S_DONE} state_t;

   localparam logic [X_W:0]   LP_SW    = (X_W+1)'(SCREEN_W);
   localparam logic [Y_W:0]   LP_SH    = (Y_W+1)'(SCREEN_H);
   localparam logic [X_W-1:0] LP_XMAX  = X_W'(SCREEN_W - 1);
   localparam logic [Y_W-1:0] LP_YMAX  = Y_W'(SCREEN_H - 1);
   localparam logic [1:0]     LP_DRAIN = 2'(ROM_LAT - 1);

   state_t r_state, w_next;

   logic [X_W-1:0] r_x, r_x0, r_xe;
   logic [Y_W-1:0] r_y, r_ye;
   logic [1:0]     r_drain;

   logic           r_pv [ROM_LAT];
   logic [X_W-1:0] r_px [ROM_LAT];
   logic [Y_W-1:0] r_py [ROM_LAT];

   logic [X_W:0]   w_sum_x;
   logic [Y_W:0]   w_sum_y;
   logic [X_W-1:0] w_x0, w_xe;
   logic [Y_W-1:0] w_y0, w_ye;
   logic           w_empty, w_row_end, w_last;

   // Sums are one bit wider than the coordinates so x0+w cannot wrap before clipping.
   always_comb begin
      w_sum_x = {1'b0, bus.rect_x0} + {1'b0, bus.rect_w};
      w_sum_y = {1'b0, bus.rect_y0} + {1'b0, bus.rect_h};
      w_x0    = '0;
      w_y0    = '0;
      w_xe    = LP_XMAX;
      w_ye    = LP_YMAX;
      w_empty = 1'b0;
      if (!bus.full_screen) begin
         w_x0    = bus.rect_x0;
         w_y0    = bus.rect_y0;
         w_xe    = (w_sum_x > LP_SW) ? LP_XMAX : X_W'(w_sum_x - (X_W+1)'(1));
         w_ye    = (w_sum_y > LP_SH) ? LP_YMAX : Y_W'(w_sum_y - (Y_W+1)'(1));
         w_empty = (bus.rect_w == '0) || (bus.rect_h == '0) ||
                   ({1'b0, bus.rect_x0} >= LP_SW) || ({1'b0, bus.rect_y0} >= LP_SH);
      end
   end

   assign w_row_end = (r_x == r_xe);
   assign w_last    = w_row_end && (r_y == r_ye);

   always_ff @(posedge i_clock or negedge i_resetn) begin
      if (!i_resetn) r_state <= S_IDLE;
      else           r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (bus.start) w_next = w_empty ? S_SPRITE : S_SCAN;
         S_SCAN:   if (w_last) w_next = S_DRAIN;
         S_DRAIN:  if (r_drain == 2'd0) w_next = S_SPRITE;
         S_SPRITE: if (bus.sprite_done) w_next = S_DONE;
         S_DONE:   w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clock or negedge i_resetn) begin
      if (!i_resetn) begin
         r_x     <= '0;
         r_y     <= '0;
         r_x0    <= '0;
         r_xe    <= '0;
         r_ye    <= '0;
         r_drain <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  r_x  <= w_x0;
                  r_y  <= w_y0;
                  r_x0 <= w_x0;
                  r_xe <= w_xe;
                  r_ye <= w_ye;
               end
            end
            S_SCAN: begin
               if (w_row_end) begin
                  r_x <= r_x0;
                  if (!w_last) r_y <= r_y + Y_W'(1);
               end else begin
                  r_x <= r_x + X_W'(1);
               end
               if (w_last) r_drain <= LP_DRAIN;
            end
            S_DRAIN: r_drain <= r_drain - 2'd1;
            default: ;
         endcase
      end
   end

   // Address and valid travel together so each plot lines up with its ROM data.
   always_ff @(posedge i_clock or negedge i_resetn) begin
      if (!i_resetn) begin
         for (int i = 0; i < ROM_LAT; i++) begin
            r_pv[i] <= 1'b0;
            r_px[i] <= '0;
            r_py[i] <= '0;
         end
      end else begin
         r_pv[0] <= (r_state == S_SCAN);
         r_px[0] <= r_x;
         r_py[0] <= r_y;
         for (int i = 1; i < ROM_LAT; i++) begin
            r_pv[i] <= r_pv[i-1];
            r_px[i] <= r_px[i-1];
            r_py[i] <= r_py[i-1];
         end
      end
   end

   assign bus.rom_x       = r_x;
   assign bus.rom_y       = r_y;
   assign bus.vga_plot    = r_pv[ROM_LAT-1];
   assign bus.vga_x       = r_px[ROM_LAT-1];
   assign bus.vga_y       = r_py[ROM_LAT-1];
   // ROM data becomes valid in the same cycle as the delayed strobe, so it is forwarded directly.
   assign bus.vga_color   = r_pv[ROM_LAT-1] ? bus.rom_color : '0;
   assign bus.sprite_go   = (r_state == S_SPRITE);
   assign bus.busy        = (r_state != S_IDLE);
   assign bus.done_redraw = (r_state == S_DONE);
endmodule

// File: tb/tb_region_redraw_engine.sv
// Directed bench for region_redraw_engine: one instance with ROM_LAT=1, one with ROM_LAT=3,
// each fed by a registered background ROM returning (x^y)&7.
module tb_region_redraw_engine;
   logic clk = 1'b0;
   logic rst1 = 1'b0;
   logic rst3 = 1'b0;
   int   cyc = 0;
   int   n_tests = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   region_redraw_engine_if #(.X_W(9), .Y_W(8), .COLOR_W(3)) b1 ();
   region_redraw_engine_if #(.X_W(9), .Y_W(8), .COLOR_W(3)) b3 ();

   region_redraw_engine #(.ROM_LAT(1)) u_dut1 (.i_clock(clk), .i_resetn(rst1), .bus(b1));
   region_redraw_engine #(.ROM_LAT(3)) u_dut3 (.i_clock(clk), .i_resetn(rst3), .bus(b3));

   logic [2:0] rom3_a, rom3_b;
   always @(posedge clk) begin
      b1.rom_color <= 3'(b1.rom_x ^ 9'(b1.rom_y));
      rom3_a       <= 3'(b3.rom_x ^ 9'(b3.rom_y));
      rom3_b       <= rom3_a;
      b3.rom_color <= rom3_b;
   end

   typedef struct {int x; int y; int c; int t;} plot_t;
   plot_t q1[$];
   plot_t q3[$];

   always @(negedge clk) begin
      if (b1.vga_plot === 1'b1) q1.push_back('{int'(b1.vga_x), int'(b1.vga_y), int'(b1.vga_color), cyc});
      if (b3.vga_plot === 1'b1) q3.push_back('{int'(b3.vga_x), int'(b3.vga_y), int'(b3.vga_color), cyc});
   end

   task automatic test_reset;
      @(negedge clk);
      n_tests++;
      if ({b1.vga_plot, b1.busy, b1.sprite_go, b1.done_redraw} !== 4'b0) begin
         n_fail++;
         $display("FAIL reset_ctl1: got %b expected 0000", {b1.vga_plot, b1.busy, b1.sprite_go, b1.done_redraw});
      end
      n_tests++;
      if ({b1.vga_x, b1.vga_y, b1.vga_color, b1.rom_x, b1.rom_y} !== 37'b0) begin
         n_fail++;
         $display("FAIL reset_coord1: got %h expected 0", {b1.vga_x, b1.vga_y, b1.vga_color, b1.rom_x, b1.rom_y});
      end
      n_tests++;
      if ({b3.vga_plot, b3.busy, b3.sprite_go, b3.done_redraw} !== 4'b0) begin
         n_fail++;
         $display("FAIL reset_ctl3: got %b expected 0000", {b3.vga_plot, b3.busy, b3.sprite_go, b3.done_redraw});
      end
      rst1 = 1'b1;
      rst3 = 1'b1;
      @(negedge clk);
      @(negedge clk);
      n_tests++;
      if ({b1.vga_plot, b1.busy, b1.sprite_go, b1.done_redraw, b3.busy} !== 5'b0) begin
         n_fail++;
         $display("FAIL reset_release: got %b expected 00000",
                  {b1.vga_plot, b1.busy, b1.sprite_go, b1.done_redraw, b3.busy});
      end
   endtask

   // Runs one region on the ROM_LAT=1 instance and checks plots, handoff and completion.
   task automatic run1(input string nm, input bit fs, input int x0, input int y0, input int w,
                       input int h, input int exs, input int exe, input int eys, input int eye,
                       input int hold);
      int t0, sg, errs, n_exp, wd, ex, ey, exp_sg;
      bit to;
      wd    = exe - exs + 1;
      n_exp = (exe >= exs && eye >= eys) ? wd * (eye - eys + 1) : 0;
      q1.delete();
      @(negedge clk);
      b1.full_screen = fs;
      b1.rect_x0 = 9'(x0);
      b1.rect_y0 = 8'(y0);
      b1.rect_w  = 9'(w);
      b1.rect_h  = 8'(h);
      b1.start   = 1'b1;
      t0 = cyc;
      @(negedge clk);
      b1.start = 1'b0;
      b1.full_screen = 1'b0;
      b1.rect_x0 = 9'd123;
      b1.rect_y0 = 8'd45;
      b1.rect_w  = 9'd7;
      b1.rect_h  = 8'd9;
      to = 1'b1;
      for (int i = 0; i < 80000; i++) begin
         if (b1.sprite_go === 1'b1) begin
            to = 1'b0;
            break;
         end
         @(negedge clk);
      end
      sg = cyc;
      n_tests++;
      if (to) begin
         n_fail++;
         $display("FAIL %s timeout: sprite_go never rose, expected within 80000 cycles", nm);
      end
      n_tests++;
      if (q1.size() !== n_exp) begin
         n_fail++;
         $display("FAIL %s count: got %0d plots expected %0d", nm, q1.size(), n_exp);
      end
      errs = 0;
      for (int i = 0; i < q1.size() && i < n_exp; i++) begin
         ex = exs + i % wd;
         ey = eys + i / wd;
         if (q1[i].x != ex || q1[i].y != ey || q1[i].c != ((ex ^ ey) & 7) || q1[i].t != t0 + 2 + i) begin
            if (errs < 3)
               $display("  %s plot %0d: got (%0d,%0d) c%0d @%0d expected (%0d,%0d) c%0d @%0d", nm, i,
                        q1[i].x, q1[i].y, q1[i].c, q1[i].t, ex, ey, (ex ^ ey) & 7, t0 + 2 + i);
            errs++;
         end
      end
      n_tests++;
      if (errs != 0) begin
         n_fail++;
         $display("FAIL %s order: got %0d bad plots expected 0", nm, errs);
      end
      exp_sg = (n_exp > 0) ? t0 + 2 + n_exp : t0 + 1;
      n_tests++;
      if (sg !== exp_sg) begin
         n_fail++;
         $display("FAIL %s sprite_go_time: got cycle %0d expected %0d", nm, sg - t0, exp_sg - t0);
      end
      errs = 0;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         if (b1.sprite_go !== 1'b1 || b1.done_redraw !== 1'b0) errs++;
      end
      if (hold > 0) begin
         n_tests++;
         if (errs != 0) begin
            n_fail++;
            $display("FAIL %s hold: got %0d bad cycles expected 0", nm, errs);
         end
      end
      b1.sprite_done = 1'b1;
      @(negedge clk);
      b1.sprite_done = 1'b0;
      n_tests++;
      if ({b1.done_redraw, b1.sprite_go, b1.busy} !== 3'b101) begin
         n_fail++;
         $display("FAIL %s done_pulse: got %b expected 101", nm, {b1.done_redraw, b1.sprite_go, b1.busy});
      end
      @(negedge clk);
      n_tests++;
      if ({b1.done_redraw, b1.busy} !== 2'b00) begin
         n_fail++;
         $display("FAIL %s done_clear: got %b expected 00", nm, {b1.done_redraw, b1.busy});
      end
   endtask

   task automatic test_stray_sprite_done;
      int errs = 0;
      b1.sprite_done = 1'b1;
      repeat (3) begin
         @(negedge clk);
         if ({b1.busy, b1.done_redraw, b1.sprite_go} !== 3'b000) errs++;
      end
      b1.sprite_done = 1'b0;
      n_tests++;
      if (errs != 0) begin
         n_fail++;
         $display("FAIL stray_sprite_done: got %0d bad cycles expected 0", errs);
      end
   endtask

   task automatic test_reset_mid_scan;
      @(negedge clk);
      b1.full_screen = 1'b0;
      b1.rect_x0 = 9'd0;
      b1.rect_y0 = 8'd0;
      b1.rect_w  = 9'd100;
      b1.rect_h  = 8'd10;
      b1.start   = 1'b1;
      @(negedge clk);
      b1.start = 1'b0;
      repeat (4) @(negedge clk);
      n_tests++;
      if ({b1.busy, b1.vga_plot} !== 2'b11) begin
         n_fail++;
         $display("FAIL mid_scan_active: got %b expected 11", {b1.busy, b1.vga_plot});
      end
      rst1 = 1'b0;
      @(negedge clk);
      n_tests++;
      if ({b1.vga_plot, b1.busy, b1.sprite_go} !== 3'b000) begin
         n_fail++;
         $display("FAIL mid_scan_reset: got %b expected 000", {b1.vga_plot, b1.busy, b1.sprite_go});
      end
      rst1 = 1'b1;
      @(negedge clk);
      run1("restart", 1'b0, 10, 20, 4, 3, 10, 13, 20, 22, 0);
   endtask

   task automatic test_lat3;
      int t0, sg, errs;
      int ex[4] = '{0, 1, 0, 1};
      int ey[4] = '{0, 0, 1, 1};
      bit to;
      q3.delete();
      @(negedge clk);
      b3.full_screen = 1'b0;
      b3.rect_x0 = 9'd0;
      b3.rect_y0 = 8'd0;
      b3.rect_w  = 9'd2;
      b3.rect_h  = 8'd2;
      b3.start   = 1'b1;
      t0 = cyc;
      @(negedge clk);
      b3.start = 1'b0;
      @(negedge clk);
      b3.start = 1'b1;
      @(negedge clk);
      b3.start = 1'b0;
      to = 1'b1;
      for (int i = 0; i < 100; i++) begin
         if (b3.sprite_go === 1'b1) begin
            to = 1'b0;
            break;
         end
         @(negedge clk);
      end
      sg = cyc;
      n_tests++;
      if (to) begin
         n_fail++;
         $display("FAIL lat3 timeout: sprite_go never rose, expected within 100 cycles");
      end
      n_tests++;
      if (q3.size() !== 4) begin
         n_fail++;
         $display("FAIL lat3 count: got %0d plots expected 4", q3.size());
      end
      errs = 0;
      for (int i = 0; i < q3.size() && i < 4; i++)
         if (q3[i].x != ex[i] || q3[i].y != ey[i] || q3[i].c != ((ex[i] ^ ey[i]) & 7) || q3[i].t != t0 + 4 + i)
            errs++;
      n_tests++;
      if (errs != 0) begin
         n_fail++;
         $display("FAIL lat3 order: got %0d bad plots expected 0", errs);
      end
      n_tests++;
      if (sg !== t0 + 8) begin
         n_fail++;
         $display("FAIL lat3 sprite_go_time: got cycle %0d expected 8", sg - t0);
      end
      b3.sprite_done = 1'b1;
      @(negedge clk);
      b3.sprite_done = 1'b0;
      n_tests++;
      if (b3.done_redraw !== 1'b1) begin
         n_fail++;
         $display("FAIL lat3 done_pulse: got %b expected 1", b3.done_redraw);
      end
      errs = 0;
      repeat (10) begin
         @(negedge clk);
         if ({b3.busy, b3.vga_plot, b3.done_redraw} !== 3'b000) errs++;
      end
      n_tests++;
      if (errs != 0 || q3.size() !== 4) begin
         n_fail++;
         $display("FAIL lat3 no_requeue: got %0d busy cycles, %0d plots expected 0, 4", errs, q3.size());
      end
   endtask

   initial begin
      b1.start = 1'b0; b1.full_screen = 1'b0; b1.sprite_done = 1'b0;
      b1.rect_x0 = '0; b1.rect_y0 = '0; b1.rect_w = '0; b1.rect_h = '0;
      b3.start = 1'b0; b3.full_screen = 1'b0; b3.sprite_done = 1'b0;
      b3.rect_x0 = '0; b3.rect_y0 = '0; b3.rect_w = '0; b3.rect_h = '0;
      repeat (2) @(negedge clk);
      test_reset();
      run1("rect", 1'b0, 10, 20, 4, 3, 10, 13, 20, 22, 0);
      run1("clip", 1'b0, 318, 238, 5, 5, 318, 319, 238, 239, 0);
      run1("empty_w", 1'b0, 10, 20, 0, 3, 0, -1, 0, -1, 0);
      run1("empty_x0", 1'b0, 320, 5, 4, 3, 0, -1, 0, -1, 0);
      run1("sprite_hold", 1'b0, 5, 6, 2, 1, 5, 6, 6, 6, 50);
      test_stray_sprite_done();
      test_lat3();
      test_reset_mid_scan();
      run1("full_screen", 1'b1, 77, 88, 3, 3, 0, 319, 0, 239, 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
